// File: rtl/twiddle_mul.sv
// twiddle_mul: twiddle multiply stage after the radix-2 butterfly of a
// 512-point, 16-lane FFT. do1 is delay-matched; do2 is rotated by
// W_N^k (k = blk*NUM + lane), rounded half-up and saturated. Latency 3.

// One lane: twiddle ROM lookup, 3-stage complex multiply, matched do1 delay.
module twiddle_lane #(
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = 10,
    parameter int TW_WIDTH  = 9,
    parameter int NUM       = 16,
    parameter int DATA      = 512,
    parameter int BW        = 4,
    parameter int LANE      = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  en,
    input  logic [BW-1:0]               blk,
    input  logic signed [IN_WIDTH-1:0]  a,
    input  logic signed [IN_WIDTH-1:0]  b,
    input  logic signed [IN_WIDTH-1:0]  t_re,
    input  logic signed [IN_WIDTH-1:0]  t_im,
    output logic signed [OUT_WIDTH-1:0] top_re,
    output logic signed [OUT_WIDTH-1:0] top_im,
    output logic signed [OUT_WIDTH-1:0] bot_re,
    output logic signed [OUT_WIDTH-1:0] bot_im
);
    localparam int KW   = $clog2(DATA/2);
    localparam int PW   = IN_WIDTH + TW_WIDTH;
    localparam int SW   = PW + 1;
    localparam int FRAC = TW_WIDTH - 2;

    localparam logic [KW:0]            HALF = (KW+1)'(DATA/2);
    localparam logic [KW:0]            QTR  = (KW+1)'(DATA/4);
    localparam logic signed [SW-1:0]   RND  = SW'(1 << (FRAC-1));
    localparam logic signed [SW-1:0]   MAXV = SW'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [SW-1:0]   MINV = SW'(-(1 << (OUT_WIDTH-1)));

    // Quarter-wave table round(128*sin(2*pi*j/512)), j = 0..128.
    // sin/cos over the half circle k = 0..255 fold onto it by symmetry.
    localparam int QSIN [0:DATA/4] = '{
          0,   2,   3,   5,   6,   8,   9,  11,  13,  14,  16,  17,  19,  20,  22,  23,
         25,  27,  28,  30,  31,  33,  34,  36,  37,  39,  40,  42,  43,  45,  46,  48,
         49,  50,  52,  53,  55,  56,  58,  59,  60,  62,  63,  64,  66,  67,  68,  70,
         71,  72,  74,  75,  76,  78,  79,  80,  81,  82,  84,  85,  86,  87,  88,  89,
         91,  92,  93,  94,  95,  96,  97,  98,  99, 100, 101, 102, 103, 104, 105, 106,
        106, 107, 108, 109, 110, 111, 111, 112, 113, 114, 114, 115, 116, 116, 117, 118,
        118, 119, 119, 120, 121, 121, 122, 122, 122, 123, 123, 124, 124, 125, 125, 125,
        126, 126, 126, 126, 127, 127, 127, 127, 127, 128, 128, 128, 128, 128, 128, 128,
        128
    };

    function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [SW-1:0] x);
        if (x > MAXV)      return OUT_WIDTH'(MAXV);
        else if (x < MINV) return OUT_WIDTH'(MINV);
        else               return OUT_WIDTH'(x);
    endfunction

    logic [KW-1:0]              k;
    logic [KW:0]                k_ext, sin_idx, cos_idx;
    logic                       cos_neg;
    logic signed [TW_WIDTH-1:0] c_rom, s_rom;

    logic signed [IN_WIDTH-1:0] a_q, b_q, t1_re, t1_im, t2_re, t2_im;
    logic signed [TW_WIDTH-1:0] c_q, s_q;
    logic signed [PW-1:0]       ac_q, bs_q, bc_q, as_q;
    logic signed [SW-1:0]       re_sum, im_sum, re_rnd, im_rnd;

    assign k = KW'(32'(blk) * NUM + LANE);

    // Twiddle ROM: fold k onto the quarter table; cos goes negative past pi/2.
    always_comb begin
        k_ext   = {1'b0, k};
        cos_neg = 1'b0;
        sin_idx = k_ext;
        cos_idx = QTR - k_ext;
        if (k_ext > QTR) begin
            sin_idx = HALF - k_ext;
            cos_idx = k_ext - QTR;
            cos_neg = 1'b1;
        end
        s_rom = TW_WIDTH'(QSIN[sin_idx[KW-1:0]]);
        c_rom = cos_neg ? TW_WIDTH'(-QSIN[cos_idx[KW-1:0]])
                        : TW_WIDTH'(QSIN[cos_idx[KW-1:0]]);
    end

    // S1: capture operands and twiddle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0; b_q <= '0; c_q <= '0; s_q <= '0;
            t1_re <= '0; t1_im <= '0;
        end else if (en[0]) begin
            a_q <= a; b_q <= b; c_q <= c_rom; s_q <= s_rom;
            t1_re <= t_re; t1_im <= t_im;
        end
    end

    // S2: the four partial products.
    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q <= '0; bs_q <= '0; bc_q <= '0; as_q <= '0;
            t2_re <= '0; t2_im <= '0;
        end else if (en[1]) begin
            ac_q <= PW'(a_q) * PW'(c_q);
            bs_q <= PW'(b_q) * PW'(s_q);
            bc_q <= PW'(b_q) * PW'(c_q);
            as_q <= PW'(a_q) * PW'(s_q);
            t2_re <= t1_re; t2_im <= t1_im;
        end
    end

    // (a+jb)(c-js) = (ac+bs) + j(bc-as); round half up at the s1.7 binary point.
    always_comb begin
        re_sum = SW'(ac_q) + SW'(bs_q);
        im_sum = SW'(bc_q) - SW'(as_q);
        re_rnd = (re_sum + RND) >>> FRAC;
        im_rnd = (im_sum + RND) >>> FRAC;
    end

    // S3: saturate and register; holds while no vector is in this stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_re <= '0; top_im <= '0; bot_re <= '0; bot_im <= '0;
        end else if (en[2]) begin
            top_re <= sat_out(SW'(t2_re));
            top_im <= sat_out(SW'(t2_im));
            bot_re <= sat_out(re_rnd);
            bot_im <= sat_out(im_rnd);
        end
    end
endmodule

// Top: block counter, valid/frame pipeline, lane array.
module twiddle_mul #(
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = 10,
    parameter int TW_WIDTH  = 9,
    parameter int NUM       = 16,
    parameter int DATA      = 512
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic [NUM-1:0][IN_WIDTH-1:0]   do1_re,
    input  logic [NUM-1:0][IN_WIDTH-1:0]   do1_im,
    input  logic [NUM-1:0][IN_WIDTH-1:0]   do2_re,
    input  logic [NUM-1:0][IN_WIDTH-1:0]   do2_im,
    output logic [NUM-1:0][OUT_WIDTH-1:0]  top_re,
    output logic [NUM-1:0][OUT_WIDTH-1:0]  top_im,
    output logic [NUM-1:0][OUT_WIDTH-1:0]  bot_re,
    output logic [NUM-1:0][OUT_WIDTH-1:0]  bot_im,
    output logic                           valid_out,
    output logic                           frame_done
);
    localparam int STAGES = 3;
    localparam int BLK    = DATA / 2 / NUM;
    localparam int BW     = $clog2(BLK);

    logic [BW-1:0]       blk;
    logic                last_in;
    logic [STAGES-1:0]   vld_q, last_q;
    logic [STAGES:0]     vld_pipe, last_pipe;

    assign last_in   = valid_in && (blk == BW'(BLK-1));
    assign vld_pipe  = {vld_q, valid_in};
    assign last_pipe = {last_q, last_in};
    assign valid_out  = vld_pipe[STAGES];
    assign frame_done = last_pipe[STAGES];

    // Vector index within the frame; only accepted vectors advance it.
    always_ff @(posedge clk) begin
        if (rst)           blk <= '0;
        else if (valid_in) blk <= (blk == BW'(BLK-1)) ? '0 : blk + 1'b1;
    end

    // Valid and end-of-frame markers ride alongside the data; reset drops in-flight vectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= vld_pipe[STAGES-1:0];
            last_q <= last_pipe[STAGES-1:0];
        end
    end

    for (genvar l = 0; l < NUM; l++) begin : g_lane
        twiddle_lane #(
            .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .TW_WIDTH(TW_WIDTH),
            .NUM(NUM), .DATA(DATA), .BW(BW), .LANE(l)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (vld_pipe[STAGES-1:0]),
            .blk    (blk),
            .a      (do2_re[l]),
            .b      (do2_im[l]),
            .t_re   (do1_re[l]),
            .t_im   (do1_im[l]),
            .top_re (top_re[l]),
            .top_im (top_im[l]),
            .bot_re (bot_re[l]),
            .bot_im (bot_im[l])
        );
    end
endmodule

// File: tb/tb_twiddle_mul.sv
// tb_twiddle_mul: directed vectors into twiddle_mul; expected vectors are
// queued at issue and checked by a negedge monitor whenever valid_out is high.
module tb_twiddle_mul;
    localparam int IN_WIDTH = 10, OUT_WIDTH = 10, TW_WIDTH = 9, NUM = 16, DATA = 512;
    localparam int BLK = DATA / 2 / NUM;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst, valid_in, valid_out, frame_done;
    logic [NUM-1:0][IN_WIDTH-1:0]  do1_re, do1_im, do2_re, do2_im;
    logic [NUM-1:0][OUT_WIDTH-1:0] top_re, top_im, bot_re, bot_im;

    twiddle_mul #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .TW_WIDTH(TW_WIDTH),
                  .NUM(NUM), .DATA(DATA)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .do1_re(do1_re), .do1_im(do1_im), .do2_re(do2_re), .do2_im(do2_im),
        .top_re(top_re), .top_im(top_im), .bot_re(bot_re), .bot_im(bot_im),
        .valid_out(valid_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NUM-1:0][OUT_WIDTH-1:0] tre, tim, bre, bim;
        logic fd;
        int   due;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    bit   shown;
    int   n_tests = 0, n_fail = 0;
    int   mblk = 0;

    function automatic int tw_c(input int k);
        return $rtoi($floor(128.0 * $cos(2.0 * PI * real'(k) / real'(DATA)) + 0.5));
    endfunction
    function automatic int tw_s(input int k);
        return $rtoi($floor(128.0 * $sin(2.0 * PI * real'(k) / real'(DATA)) + 0.5));
    endfunction
    function automatic int rsat(input int x);
        int r;
        r = (x + 64) >>> 7;
        if (r > 511)  r = 511;
        if (r < -512) r = -512;
        return r;
    endfunction

    task automatic chk(input string name, input logic [NUM*OUT_WIDTH-1:0] got,
                       input logic [NUM*OUT_WIDTH-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic rand_vec();
        for (int l = 0; l < NUM; l++) begin
            do1_re[l] = IN_WIDTH'($urandom);
            do1_im[l] = IN_WIDTH'($urandom);
            do2_re[l] = IN_WIDTH'($urandom);
            do2_im[l] = IN_WIDTH'($urandom);
        end
    endtask

    // Drive one vector for a cycle and queue its expected result; ovr replaces
    // the model's lane-0 bot value with a hand-computed one.
    task automatic issue(input bit ovr, input int h_re, input int h_im);
        exp_t e;
        int a, b, c, s, k;
        for (int l = 0; l < NUM; l++) begin
            k = mblk * NUM + l;
            a = $signed(do2_re[l]);
            b = $signed(do2_im[l]);
            c = tw_c(k);
            s = tw_s(k);
            e.bre[l] = OUT_WIDTH'(rsat(a * c + b * s));
            e.bim[l] = OUT_WIDTH'(rsat(b * c - a * s));
            e.tre[l] = do1_re[l];
            e.tim[l] = do1_im[l];
        end
        if (ovr) begin
            e.bre[0] = OUT_WIDTH'(h_re);
            e.bim[0] = OUT_WIDTH'(h_im);
        end
        e.fd  = (mblk == BLK - 1);
        e.due = cyc + 3;
        sb.push_back(e);
        mblk = (mblk + 1) % BLK;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: every valid_out must match the oldest queued expectation.
    always @(negedge clk) begin
        if (frame_done === 1'b1 && valid_out !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL fd_alone cyc=%0d got frame_done=1 valid_out=%b want frame_done only with valid_out", cyc, valid_out);
        end
        if (valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_out cyc=%0d got valid_out=1 want no output", cyc);
            end else begin
                me = sb.pop_front();
                n_tests++;
                if ({top_re, top_im, bot_re, bot_im} !== {me.tre, me.tim, me.bre, me.bim}) begin
                    n_fail++;
                    shown = 1'b0;
                    for (int l = 0; l < NUM; l++) begin
                        if (!shown && {top_re[l], top_im[l], bot_re[l], bot_im[l]} !==
                                      {me.tre[l], me.tim[l], me.bre[l], me.bim[l]}) begin
                            shown = 1'b1;
                            $display("FAIL data cyc=%0d lane %0d got top=(%0d,%0d) bot=(%0d,%0d) want top=(%0d,%0d) bot=(%0d,%0d)",
                                     cyc, l, $signed(top_re[l]), $signed(top_im[l]), $signed(bot_re[l]), $signed(bot_im[l]),
                                     $signed(me.tre[l]), $signed(me.tim[l]), $signed(me.bre[l]), $signed(me.bim[l]));
                        end
                    end
                end
                n_tests++;
                if (frame_done !== me.fd) begin
                    n_fail++;
                    $display("FAIL frame_done cyc=%0d got %b want %b", cyc, frame_done, me.fd);
                end
                n_tests++;
                if (cyc != me.due) begin
                    n_fail++;
                    $display("FAIL latency got output at cyc %0d want cyc %0d", cyc, me.due);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0;
        do1_re = '0; do1_im = '0; do2_re = '0; do2_im = '0;
        idle(3);
        chk("rst_top_re", top_re, '0);
        chk("rst_top_im", top_im, '0);
        chk("rst_bot_re", bot_re, '0);
        chk("rst_bot_im", bot_im, '0);
        chk("rst_valid_out", {{(NUM*OUT_WIDTH-1){1'b0}}, valid_out}, '0);
        chk("rst_frame_done", {{(NUM*OUT_WIDTH-1){1'b0}}, frame_done}, '0);
        rst = 1'b0;
        idle(1);

        // Frame A: identity, saturation, -j rotation; random gaps.
        for (int v = 0; v < BLK; v++) begin
            rand_vec();
            if (v == 0) begin
                do2_re[0] = 10'sd100; do2_im[0] = -10'sd50;
                do1_re[0] = 10'sd7;   do1_im[0] = -10'sd3;
                issue(1'b1, 100, -50);
            end else if (v == 4) begin
                do2_re[0] = 10'sd511; do2_im[0] = 10'sd511;
                issue(1'b1, 511, 0);
            end else if (v == 8) begin
                do2_re[0] = 10'sd100; do2_im[0] = -10'sd50;
                issue(1'b1, -50, -100);
            end else begin
                issue(1'b0, 0, 0);
            end
            idle($urandom_range(0, 3));
        end

        // Frame B: the 17th vector is back at blk 0; reset mid-frame.
        for (int v = 0; v < 5; v++) begin
            rand_vec();
            if (v == 0) begin
                do2_re[0] = 10'sd100; do2_im[0] = -10'sd50;
                issue(1'b1, 100, -50);
            end else begin
                issue(1'b0, 0, 0);
            end
        end
        rand_vec();
        rst = 1'b1; valid_in = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; valid_in = 1'b0;
        chk("rst_flush_valid", {{(NUM*OUT_WIDTH-1){1'b0}}, valid_out}, '0);
        sb.delete();
        mblk = 0;
        idle(2);

        // Frame C: back-to-back after reset; blk restarts at 0.
        for (int v = 0; v < BLK; v++) begin
            rand_vec();
            if (v == 0) begin
                do2_re[0] = 10'sd100; do2_im[0] = -10'sd50;
                issue(1'b1, 100, -50);
            end else if (v == 4) begin
                do2_re[0] = -10'sd512; do2_im[0] = -10'sd512;
                issue(1'b1, -512, 0);
            end else if (v == 8) begin
                do2_re[0] = 10'sd100; do2_im[0] = -10'sd50;
                issue(1'b1, -50, -100);
            end else begin
                issue(1'b0, 0, 0);
            end
        end

        idle(8);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d outputs missing want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
